// File: rtl/qhy_sequencer_pkg.sv
// Shared types and default sizes for the Q-row sequencer (4x4 MIMO y*Q rows).
package qhy_sequencer_pkg;

  localparam int unsigned DATA_W = 28;
  localparam int unsigned N_ROW  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  // One complex sample as packed on y_in / q_rd_data: real in the low half.
  typedef struct packed {
    logic signed [DATA_W-1:0] im;
    logic signed [DATA_W-1:0] re;
  } cplx_t;

  // Four samples, element 0 in the least significant position.
  typedef cplx_t [3:0] cvec_t;

endpackage

// File: rtl/qhy_sequencer_if.sv
// Input-vector, Q-row read and result handshake bundle of the sequencer.
interface qhy_sequencer_if #(
  parameter int unsigned DATA_W = qhy_sequencer_pkg::DATA_W
);

  logic                     in_valid;
  logic                     in_ready;
  logic [8*DATA_W-1:0]      y_in;
  logic                     q_rd_en;
  logic [1:0]               q_rd_addr;
  logic [8*DATA_W-1:0]      q_rd_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [1:0]               out_row;
  logic signed [DATA_W-1:0] out_real;
  logic signed [DATA_W-1:0] out_imag;
  logic                     frame_done;

  modport master (
    output in_valid, y_in, q_rd_data, out_ready,
    input  in_ready, q_rd_en, q_rd_addr, out_valid, out_row, out_real, out_imag,
           frame_done
  );

  modport slave (
    input  in_valid, y_in, q_rd_data, out_ready,
    output in_ready, q_rd_en, q_rd_addr, out_valid, out_row, out_real, out_imag,
           frame_done
  );

endinterface

// File: rtl/qhy_dot4.sv
// Combinational four-term complex dot product sum(y_k * q_k), no conjugation.
module qhy_dot4 #(
  parameter int unsigned DATA_W = 28,
  parameter int unsigned ACC_W  = 2*DATA_W + 2
) (
  input  logic [8*DATA_W-1:0]     y,
  input  logic [8*DATA_W-1:0]     q,
  output logic signed [ACC_W-1:0] re,
  output logic signed [ACC_W-1:0] im
);

  logic signed [2*DATA_W-1:0] p_rr [4];
  logic signed [2*DATA_W-1:0] p_ii [4];
  logic signed [2*DATA_W-1:0] p_ri [4];
  logic signed [2*DATA_W-1:0] p_ir [4];

  // Per-term full-precision partial products.
  for (genvar k = 0; k < 4; k++) begin : g_term
    logic signed [DATA_W-1:0] yr, yi, qr, qi;
    assign yr      = y[(2*k)*DATA_W +: DATA_W];
    assign yi      = y[(2*k+1)*DATA_W +: DATA_W];
    assign qr      = q[(2*k)*DATA_W +: DATA_W];
    assign qi      = q[(2*k+1)*DATA_W +: DATA_W];
    assign p_rr[k] = yr * qr;
    assign p_ii[k] = yi * qi;
    assign p_ri[k] = yr * qi;
    assign p_ir[k] = yi * qr;
  end

  // Sign-extended accumulation of the four complex products.
  always_comb begin
    re = '0;
    im = '0;
    for (int k = 0; k < 4; k++) begin
      re = re + ACC_W'(p_rr[k]) - ACC_W'(p_ii[k]);
      im = im + ACC_W'(p_ri[k]) + ACC_W'(p_ir[k]);
    end
  end

endmodule

// File: rtl/qhy_sequencer.sv
// Row sequencer: latches a y vector, reads N_ROW Q rows and emits y.Q_row per row.
// Optional build macro QHY_SAT_EN: saturate results instead of wrapping.
module qhy_sequencer #(
  parameter int unsigned DATA_W = qhy_sequencer_pkg::DATA_W,
  parameter int unsigned FRAC_W = 0,
  parameter int unsigned N_ROW  = qhy_sequencer_pkg::N_ROW
) (
  input logic            clk,
  input logic            rst,
  qhy_sequencer_if.slave bus
);

  import qhy_sequencer_pkg::*;

  localparam int unsigned ACC_W = 2*DATA_W + 2;
  localparam int unsigned ROW_W = 2;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROW - 1);

`ifdef QHY_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

  state_t              state;
  logic [ROW_W-1:0]    row;
  logic [8*DATA_W-1:0] y_reg;
  logic signed [ACC_W-1:0] acc_re, acc_im;
  logic                frame_done_c;

  // Drop FRAC_W fraction bits, then wrap or clamp into the output width.
  function automatic logic signed [DATA_W-1:0] fit(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> FRAC_W;
`ifdef QHY_SAT_EN
    if (sh > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (sh < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                   return sh[DATA_W-1:0];
`else
    return sh[DATA_W-1:0];
`endif
  endfunction

  // Single shared dot-product engine fed by the latched y and the live Q row.
  qhy_dot4 #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_dot4 (
    .y  (y_reg),
    .q  (bus.q_rd_data),
    .re (acc_re),
    .im (acc_im)
  );

  // y vector holding register, loaded only on frame acceptance.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && bus.in_valid) begin
      y_reg <= bus.y_in;
    end
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      row           <= '0;
      bus.in_ready  <= 1'b1;
      bus.q_rd_en   <= 1'b0;
      bus.q_rd_addr <= '0;
      bus.out_valid <= 1'b0;
      bus.out_row   <= '0;
      bus.out_real  <= '0;
      bus.out_imag  <= '0;
    end else begin
      bus.q_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            row           <= '0;
            bus.in_ready  <= 1'b0;
            bus.q_rd_en   <= 1'b1;
            bus.q_rd_addr <= '0;
            state         <= RD;
          end
        end
        RD: begin
          state <= WAIT;
        end
        WAIT: begin
          bus.out_real  <= fit(acc_re);
          bus.out_imag  <= fit(acc_im);
          bus.out_row   <= row;
          bus.out_valid <= 1'b1;
          state         <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (row == LAST_ROW) begin
              bus.in_ready <= 1'b1;
              state        <= IDLE;
            end else begin
              row           <= row + ROW_W'(1);
              bus.q_rd_en   <= 1'b1;
              bus.q_rd_addr <= row + ROW_W'(1);
              state         <= RD;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Frame end is flagged in the same cycle as the last row's handshake.
  assign frame_done_c   = !rst && (state == OUT) && bus.out_valid && bus.out_ready &&
                          (row == LAST_ROW);
  assign bus.frame_done = frame_done_c;

endmodule
